tt_pg_seq: RTL
==============

Name: tt_pg_seq

Overview:
- Power-up/power-down sequencer sitting directly upstream of the 1v8 power-gate switch cells.
- Drives each switch's ctrl input in staggered order to limit inrush current.
- Manages the gated domain's output isolation clamp and its reset.
- Simple level request from the mux controller; reports on/busy status.

Parameters:
- N_SW, 2: number of power switch cells, one ctrl bit each; must be ≥1.
- STAGE_DLY, 16: clock cycles between successive switch enables; must be ≥1.
- SETTLE_DLY, 64: cycles for rail settle after the last switch turns on, and for rail discharge after all switches turn off; must be ≥1.
- RST_DLY, 4: cycles between isolation release and reset release, and between each power-down step; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_on  input  1  level request: 1 = domain powered, 0 = domain off. Synchronous to clk.
- pg_ctrl  output  N_SW  one bit per switch cell ctrl; 1 = switch on.
- iso  output  1  isolation clamp for gated-domain outputs; 1 = clamped.
- usr_rst  output  1  active-high reset into the gated domain.
- on  output  1  domain fully powered, unclamped and out of reset.
- busy  output  1  sequence in progress; req_on changes are not acted on while busy=1.

Behaviour:
- Reset (async, immediate): pg_ctrl=0, iso=1, usr_rst=1, on=0, busy=0, state=OFF. This holds mid-sequence too; abrupt switch-off on reset is accepted.
- All outputs are registered.
- States: OFF, SW_UP, SETTLE_UP, ISO_REL, ON, DN_RST, DN_ISO, DN_WAIT. One shared down-counter and one switch index.
- OFF:
  - req_on=1 sampled at edge E0 → SW_UP, idx=0, pg_ctrl[0]=1, busy=1, counter=STAGE_DLY-1.
- SW_UP:
  - Counter decrements each cycle.
  - At zero with idx<N_SW-1: idx++, set pg_ctrl[idx], reload counter.
  - At zero with idx=N_SW-1: go to SETTLE_UP, counter=SETTLE_DLY-1.
  - Result: pg_ctrl[i] rises at E0+i*STAGE_DLY. Bits are never cleared during the up sequence.
- SETTLE_UP:
  - At zero: iso=0, go to ISO_REL, counter=RST_DLY-1.
  - iso falls at E0+N_SW*STAGE_DLY+SETTLE_DLY.
- ISO_REL:
  - At zero: usr_rst=0, on=1, busy=0, go to ON.
  - on rises RST_DLY cycles after iso falls.
- ON:
  - req_on=0 sampled at edge D0 → usr_rst=1, on=0, busy=1, go to DN_RST, counter=RST_DLY-1.
- DN_RST:
  - At zero: iso=1, go to DN_ISO, reload RST_DLY-1.
  - iso rises at D0+RST_DLY.
- DN_ISO:
  - At zero: all pg_ctrl cleared together, go to DN_WAIT, counter=SETTLE_DLY-1.
  - pg_ctrl falls at D0+2*RST_DLY.
- DN_WAIT:
  - At zero: busy=0, go to OFF. This enforces a minimum discharge time.
- Invariants, checked by assertions:
  - on=1 implies pg_ctrl all ones, iso=0, usr_rst=0.
  - iso=0 implies pg_ctrl all ones.
  - pg_ctrl≠0 implies busy or on.
- Request handling:
  - No abort: req_on toggles during busy are ignored.
  - req_on is re-evaluated only in OFF or ON. If it still differs from the current state, the opposite sequence starts on the next sampled edge.
  - A req_on pulse shorter than the sequence is therefore lost only if it has returned to its original level by the time OFF/ON is reached.
- Counter width: $clog2(max(STAGE_DLY,SETTLE_DLY,RST_DLY)). idx width: $clog2(N_SW), minimum 1.
- Delays of 1 mean a single cycle in that state.

Decomposition:
- Package tt_pg_pkg holds:
  - state encoding localparams (3-bit, the 8 states above);
  - default delay constants shared with the multiplexer controller.
- Sub-module tt_pg_seq_timer holds the loadable down-counter:
  - inputs: load, load_val;
  - output: zero flag, asserted when count==0 and not loading.
- The FSM, index and output registers remain in tt_pg_seq.

Test Plan (defaults unless noted):
- Reset, then req_on=1 at E0 → pg_ctrl=01 at E0, 11 at E0+16; iso=0 at E0+96; usr_rst=0, on=1, busy=0 at E0+100.
- From ON, req_on=0 at D0 → usr_rst=1/on=0 at D0; iso=1 at D0+4; pg_ctrl=00 at D0+8; busy=0 at D0+72.
- req_on pulse 1 for 3 cycles from OFF → full up sequence completes (on at +100). Then the down sequence starts on the next edge, since req_on=0.
- rst asserted at E0+50 (mid SETTLE_UP) → immediately pg_ctrl=0, iso=1, usr_rst=1, busy=0. Release with req_on=1 → sequence restarts from idx 0.
- N_SW=4, STAGE_DLY=1, SETTLE_DLY=1, RST_DLY=1 → pg_ctrl 0001,0011,0111,1111 on consecutive edges; iso=0 at E0+5; on at E0+6.
- Random req_on toggling for 10k cycles → all invariants hold; no pg_ctrl bit ever toggles while iso=0.

Source files
------------

// File: rtl/tt_pg_pkg.sv
// Shared definitions for the 1v8 power-gate sequencer: state encoding,
// default delay constants and small elaboration-time helpers.
package tt_pg_pkg;

  // State encoding (3 bits, 8 states)
  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_SW_UP     = 3'd1;
  localparam logic [2:0] ST_SETTLE_UP = 3'd2;
  localparam logic [2:0] ST_ISO_REL   = 3'd3;
  localparam logic [2:0] ST_ON        = 3'd4;
  localparam logic [2:0] ST_DN_RST    = 3'd5;
  localparam logic [2:0] ST_DN_ISO    = 3'd6;
  localparam logic [2:0] ST_DN_WAIT   = 3'd7;

  typedef enum logic [2:0] {
    S_OFF       = ST_OFF,
    S_SW_UP     = ST_SW_UP,
    S_SETTLE_UP = ST_SETTLE_UP,
    S_ISO_REL   = ST_ISO_REL,
    S_ON        = ST_ON,
    S_DN_RST    = ST_DN_RST,
    S_DN_ISO    = ST_DN_ISO,
    S_DN_WAIT   = ST_DN_WAIT
  } pg_state_e;

  // Default delays, also used by the multiplexer controller
  localparam int DEF_N_SW       = 2;
  localparam int DEF_STAGE_DLY  = 16;
  localparam int DEF_SETTLE_DLY = 64;
  localparam int DEF_RST_DLY    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // $clog2 with a floor of one bit so delays/counts of 1 still get a register
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/tt_pg_seq_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// The zero flag is registered from the next count, so it reads as
// "count is zero" and is never asserted in the cycle after a non-zero load.
module tt_pg_seq_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] r_cnt;
  logic          r_zero;
  logic [CW-1:0] w_cnt_next;

  // Next count: load wins, otherwise count down and hold at zero
  always_comb begin
    w_cnt_next = r_cnt;
    if (load) begin
      w_cnt_next = load_val;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  // Count register and its registered zero flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_zero <= (w_cnt_next == '0);
    end
  end

  assign zero = r_zero;

endmodule

// File: rtl/tt_pg_seq.sv
// Power-up/power-down sequencer for the gated 1v8 domain: staggers the
// switch-cell enables, then releases isolation and reset; reverses on the
// way down with a minimum rail-discharge time before the next power-up.
module tt_pg_seq
  import tt_pg_pkg::*;
#(
  parameter int N_SW       = DEF_N_SW,
  parameter int STAGE_DLY  = DEF_STAGE_DLY,
  parameter int SETTLE_DLY = DEF_SETTLE_DLY,
  parameter int RST_DLY    = DEF_RST_DLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_on,
  output logic [N_SW-1:0] pg_ctrl,
  output logic            iso,
  output logic            usr_rst,
  output logic            on,
  output logic            busy
);

  localparam int CW = clog2_min1(max3(STAGE_DLY, SETTLE_DLY, RST_DLY));
  localparam int IW = clog2_min1(N_SW);

  localparam logic [CW-1:0] STAGE_LD  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_DLY - 1);
  localparam logic [CW-1:0] RST_LD    = CW'(RST_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_SW - 1);

  pg_state_e       r_state, w_state;
  logic [IW-1:0]   r_idx, w_idx;
  logic [N_SW-1:0] r_pg, w_pg;
  logic            r_iso, w_iso;
  logic            r_usr_rst, w_usr_rst;
  logic            r_on, w_on;
  logic            r_busy, w_busy;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_zero;

  tt_pg_seq_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  // Next state, next outputs and timer reloads; every timed state reloads on exit
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_pg       = r_pg;
    w_iso      = r_iso;
    w_usr_rst  = r_usr_rst;
    w_on       = r_on;
    w_busy     = r_busy;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_OFF: begin
        if (req_on) begin
          w_state    = S_SW_UP;
          w_idx      = '0;
          w_pg[0]    = 1'b1;
          w_busy     = 1'b1;
          w_load     = 1'b1;
          w_load_val = STAGE_LD;
        end
      end
      S_SW_UP: begin
        if (w_zero) begin
          if (r_idx != IDX_LAST) begin
            w_idx       = r_idx + 1'b1;
            w_pg[w_idx] = 1'b1;
            w_load      = 1'b1;
            w_load_val  = STAGE_LD;
          end else begin
            w_state    = S_SETTLE_UP;
            w_load     = 1'b1;
            w_load_val = SETTLE_LD;
          end
        end
      end
      S_SETTLE_UP: begin
        if (w_zero) begin
          w_iso      = 1'b0;
          w_state    = S_ISO_REL;
          w_load     = 1'b1;
          w_load_val = RST_LD;
        end
      end
      S_ISO_REL: begin
        if (w_zero) begin
          w_usr_rst = 1'b0;
          w_on      = 1'b1;
          w_busy    = 1'b0;
          w_state   = S_ON;
        end
      end
      S_ON: begin
        if (!req_on) begin
          w_usr_rst  = 1'b1;
          w_on       = 1'b0;
          w_busy     = 1'b1;
          w_state    = S_DN_RST;
          w_load     = 1'b1;
          w_load_val = RST_LD;
        end
      end
      S_DN_RST: begin
        if (w_zero) begin
          w_iso      = 1'b1;
          w_state    = S_DN_ISO;
          w_load     = 1'b1;
          w_load_val = RST_LD;
        end
      end
      S_DN_ISO: begin
        if (w_zero) begin
          w_pg       = '0;
          w_state    = S_DN_WAIT;
          w_load     = 1'b1;
          w_load_val = SETTLE_LD;
        end
      end
      S_DN_WAIT: begin
        if (w_zero) begin
          w_busy  = 1'b0;
          w_state = S_OFF;
        end
      end
      default: begin
        w_state = S_OFF;
      end
    endcase
  end

  // State and output registers; reset drops the switches immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_idx     <= '0;
      r_pg      <= '0;
      r_iso     <= 1'b1;
      r_usr_rst <= 1'b1;
      r_on      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_pg      <= w_pg;
      r_iso     <= w_iso;
      r_usr_rst <= w_usr_rst;
      r_on      <= w_on;
      r_busy    <= w_busy;
    end
  end

  assign pg_ctrl = r_pg;
  assign iso     = r_iso;
  assign usr_rst = r_usr_rst;
  assign on      = r_on;
  assign busy    = r_busy;

endmodule
